// File: rtl/musb_memory_arbiter.sv
// Purpose: shares one memory slave port between the LSU instruction (I) and data (D) ports.
// Latency: 1 IDLE + N BUSY + 1 RELEASE cycles per transfer; the response is passed through in the slave's ready/error cycle.
// Backpressure: the losing port's enable simply stays pending; a stuck slave is cut off by the timeout with an error.
module musb_memory_arbiter #(
    parameter int ROUND_ROBIN    = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    // instruction port
    input  logic [31:0] i_address,
    input  logic [3:0]  i_wr,
    input  logic        i_enable,
    output logic [31:0] i_data_o,
    output logic        i_ready,
    output logic        i_error,
    // data port
    input  logic [31:0] d_address,
    input  logic [31:0] d_data_i,
    input  logic [3:0]  d_wr,
    input  logic        d_enable,
    output logic [31:0] d_data_o,
    output logic        d_ready,
    output logic        d_error,
    // memory slave port
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_o,
    output logic [3:0]  mem_wr,
    output logic        mem_enable,
    input  logic [31:0] mem_data_i,
    input  logic        mem_ready,
    input  logic        mem_error,
    // status
    output logic        arb_busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    // Last BUSY cycle index before a forced error; the counter is 8 bits wide.
    localparam int            TO_LAST_I = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
    localparam logic [7:0]    TO_LAST   = 8'(TO_LAST_I);
    localparam logic          TO_EN     = (TIMEOUT_CYCLES != 0);
    localparam logic          RR_EN     = (ROUND_ROBIN != 0);

    state_t     state;
    grant_t     grant;
    grant_t     last_grant;
    logic [7:0] tmo_cnt;

    logic       in_busy;
    logic       timeout_hit;
    logic       resp_err;
    logic       resp_rdy;
    grant_t     next_grant;

    // Response qualification: error (slave or timeout) beats ready.
    always_comb begin
        in_busy     = (state == ST_BUSY);
        timeout_hit = TO_EN && in_busy && !mem_ready && !mem_error && (tmo_cnt == TO_LAST);
        resp_err    = in_busy && (mem_error || timeout_hit);
        resp_rdy    = in_busy && mem_ready && !mem_error;
    end

    // Arbitration: single requester wins; on a tie D wins, or the port not served last in round-robin mode.
    always_comb begin
        next_grant = GNT_I;
        if (i_enable && d_enable) begin
            if (RR_EN) begin
                next_grant = (last_grant == GNT_I) ? GNT_D : GNT_I;
            end else begin
                next_grant = GNT_D;
            end
        end else if (d_enable) begin
            next_grant = GNT_D;
        end else begin
            next_grant = GNT_I;
        end
    end

    // Transfer sequencer: IDLE -> BUSY -> RELEASE -> IDLE, with BUSY-cycle timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            grant      <= GNT_I;
            last_grant <= GNT_I;
            tmo_cnt    <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tmo_cnt <= 8'd0;
                    if (i_enable || d_enable) begin
                        grant <= next_grant;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (mem_error) begin
                        state <= ST_RELEASE;
                    end else if (mem_ready) begin
                        // Only successful transfers count toward round-robin fairness.
                        last_grant <= grant;
                        state      <= ST_RELEASE;
                    end else if (timeout_hit) begin
                        state <= ST_RELEASE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                ST_RELEASE: begin
                    // One dead cycle so master and slave can both drop their handshake lines.
                    tmo_cnt <= 8'd0;
                    state   <= ST_IDLE;
                end
                default: begin
                    tmo_cnt <= 8'd0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    // Slave-side request mux; everything is held at zero outside BUSY.
    always_comb begin
        mem_enable  = in_busy;
        mem_address = 32'd0;
        mem_data_o  = 32'd0;
        mem_wr      = 4'd0;
        if (in_busy) begin
            if (grant == GNT_D) begin
                mem_address = d_address;
                mem_data_o  = d_data_i;
                mem_wr      = d_wr;
            end else begin
                mem_address = i_address;
                mem_wr      = i_wr;
            end
        end
    end

    // Master-side responses go only to the granted port; read data is a plain passthrough.
    always_comb begin
        i_data_o = mem_data_i;
        d_data_o = mem_data_i;
        i_ready  = resp_rdy && (grant == GNT_I);
        i_error  = resp_err && (grant == GNT_I);
        d_ready  = resp_rdy && (grant == GNT_D);
        d_error  = resp_err && (grant == GNT_D);
        arb_busy = (state != ST_IDLE);
    end

endmodule
